series_controller: RTL and testbench

Sequencing FSM for the Q8.8 series-evaluation `data_path`. On a `start` request it:
- loads `x` and the threshold `y`;
- presets `tmp` and `ans` to 1.0;
- runs up to `N_TERMS` term iterations of the form tmp ← tmp·x, tmp ← tmp·rom[i], ans ← ans ± tmp;
- stops early once the last term falls below `y`.

It drives every datapath control input and reports completion to the surrounding system with a `start`/`busy`/`done` handshake.

---
 rtl/series_pkg.sv | 21 ++
 rtl/series_term_counter.sv | 31 +++
 rtl/series_controller.sv | 149 ++++++++++++++
 tb/tb_series_controller.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/series_pkg.sv
// Shared definitions for the Q8.8 series-evaluation controller.
package series_pkg;

  // ROM depth, and therefore the largest legal term count.
  localparam int N_TERMS_MAX = 8;

  // 1.0 in Q8.8; the preset value for tmp and ans.
  localparam logic [15:0] Q88_ONE = 16'h0100;

  // One-hot controller states, also used to type the debug state port.
  typedef enum logic [6:0] {
    S_IDLE    = 7'b0000001,
    S_LOAD    = 7'b0000010,
    S_MUL_X   = 7'b0000100,
    S_MUL_ROM = 7'b0001000,
    S_ACC     = 7'b0010000,
    S_CHECK   = 7'b0100000,
    S_DONE    = 7'b1000000
  } series_state_t;

endpackage

// File: rtl/series_term_counter.sv
// Term counter i with a terminal-count flag at N_TERMS-1.
module series_term_counter
  import series_pkg::*;
#(
  parameter int N_TERMS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  output logic [2:0] i,
  output logic       last
);

  logic [2:0] r_i;

  // Clear has priority over increment; the controller never increments past N_TERMS-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i <= 3'd0;
    end else if (clear) begin
      r_i <= 3'd0;
    end else if (inc) begin
      r_i <= r_i + 3'd1;
    end
  end

  assign i    = r_i;
  assign last = (r_i == 3'(N_TERMS - 1));

endmodule

// File: rtl/series_controller.sv
// Sequencing FSM for the Q8.8 series-evaluation datapath.
//
// Handshake: start is sampled only in IDLE (ignored and not queued in any
// other state). busy is high in every state except IDLE. done is a one-cycle
// pulse in DONE, after which the FSM returns to IDLE for at least one cycle;
// a start held high is therefore accepted one cycle after DONE.
module series_controller
  import series_pkg::*;
#(
  parameter int N_TERMS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          alt,
  input  logic          less_cmp,
  output logic          busy,
  output logic          done,
  output logic          ld_x,
  output logic          ld_y,
  output logic          s4_in,
  output logic          s4_mult,
  output logic          init_tmp,
  output logic          init_ans,
  output logic          ld_tmp,
  output logic          ld_ans,
  output logic          sub,
  output logic          s1_rom,
  output logic          s1_x,
  output logic          s2_tmp,
  output logic          s2_x,
  output logic [7:0]    s3,
  output series_state_t dbg_state
);

  localparam logic [6:0] ST_IDLE    = 7'b0000001;
  localparam logic [6:0] ST_LOAD    = 7'b0000010;
  localparam logic [6:0] ST_MUL_X   = 7'b0000100;
  localparam logic [6:0] ST_MUL_ROM = 7'b0001000;
  localparam logic [6:0] ST_ACC     = 7'b0010000;
  localparam logic [6:0] ST_CHECK   = 7'b0100000;
  localparam logic [6:0] ST_DONE    = 7'b1000000;

  logic [6:0] r_state;
  logic [6:0] w_next_state;
  logic       r_alt_q;
  logic [2:0] w_i;
  logic       w_last;
  logic       w_clear;
  logic       w_inc;

  // Counter is held at 0 outside a run so s3 reads 0 in IDLE.
  assign w_clear = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_inc   = (r_state == ST_CHECK) && !less_cmp && !w_last;

  series_term_counter #(
    .N_TERMS (N_TERMS)
  ) u_term_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .inc   (w_inc),
    .i     (w_i),
    .last  (w_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Sign mode is captured once per run, together with the accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alt_q <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_alt_q <= alt;
    end
  end

  // Next-state logic; CHECK exits at the last term before i could wrap.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next_state = ST_LOAD;
      ST_LOAD:    w_next_state = ST_MUL_X;
      ST_MUL_X:   w_next_state = ST_MUL_ROM;
      ST_MUL_ROM: w_next_state = ST_ACC;
      ST_ACC:     w_next_state = ST_CHECK;
      ST_CHECK:   w_next_state = (less_cmp || w_last) ? ST_DONE : ST_MUL_X;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Moore output decode from registered state only, keeping init_* glitch-free.
  always_comb begin
    busy     = (r_state != ST_IDLE);
    done     = 1'b0;
    ld_x     = 1'b0;
    ld_y     = 1'b0;
    s4_in    = 1'b0;
    s4_mult  = 1'b0;
    init_tmp = 1'b0;
    init_ans = 1'b0;
    ld_tmp   = 1'b0;
    ld_ans   = 1'b0;
    sub      = 1'b0;
    s1_rom   = 1'b0;
    s1_x     = 1'b0;
    s2_tmp   = 1'b0;
    s2_x     = 1'b0;
    case (r_state)
      ST_LOAD: begin
        ld_x     = 1'b1;
        s4_in    = 1'b1;
        ld_y     = 1'b1;
        init_tmp = 1'b1;
        init_ans = 1'b1;
      end
      ST_MUL_X: begin
        ld_tmp  = 1'b1;
        s1_x    = 1'b1;
        s2_tmp  = 1'b1;
        s4_mult = 1'b1;
      end
      ST_MUL_ROM: begin
        ld_tmp  = 1'b1;
        s1_rom  = 1'b1;
        s2_tmp  = 1'b1;
        s4_mult = 1'b1;
      end
      ST_ACC: begin
        ld_ans = 1'b1;
        sub    = r_alt_q & ~w_i[0];
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign s3        = {5'b0, w_i};
  assign dbg_state = series_state_t'(r_state);

endmodule

// File: tb/tb_series_controller.sv
// Bench for series_controller: a behavioural data_path drives less_cmp, a
// loop-level reference model predicts each run, and a monitor scores DONE.
module tb_series_controller;
  import series_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT (N_TERMS = 8) ----------------
  logic start = 1'b0, alt = 1'b0, less_cmp;
  logic busy, done, ld_x, ld_y, s4_in, s4_mult, init_tmp, init_ans;
  logic ld_tmp, ld_ans, sub, s1_rom, s1_x, s2_tmp, s2_x;
  logic [7:0] s3;
  series_state_t dbg_state;

  series_controller #(.N_TERMS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .alt(alt), .less_cmp(less_cmp),
    .busy(busy), .done(done), .ld_x(ld_x), .ld_y(ld_y), .s4_in(s4_in),
    .s4_mult(s4_mult), .init_tmp(init_tmp), .init_ans(init_ans),
    .ld_tmp(ld_tmp), .ld_ans(ld_ans), .sub(sub), .s1_rom(s1_rom),
    .s1_x(s1_x), .s2_tmp(s2_tmp), .s2_x(s2_x), .s3(s3), .dbg_state(dbg_state)
  );

  // ---------------- DUT (N_TERMS = 4) ----------------
  logic start4 = 1'b0, alt4 = 1'b0, less4 = 1'b0;
  logic busy4, done4, ld_x4, ld_y4, s4_in4, s4_mult4, init_tmp4, init_ans4;
  logic ld_tmp4, ld_ans4, sub4, s1_rom4, s1_x4, s2_tmp4, s2_x4;
  logic [7:0] s3_4;
  series_state_t dbg_state4;

  series_controller #(.N_TERMS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .alt(alt4), .less_cmp(less4),
    .busy(busy4), .done(done4), .ld_x(ld_x4), .ld_y(ld_y4), .s4_in(s4_in4),
    .s4_mult(s4_mult4), .init_tmp(init_tmp4), .init_ans(init_ans4),
    .ld_tmp(ld_tmp4), .ld_ans(ld_ans4), .sub(sub4), .s1_rom(s1_rom4),
    .s1_x(s1_x4), .s2_tmp(s2_tmp4), .s2_x(s2_x4), .s3(s3_4), .dbg_state(dbg_state4)
  );

  // ---------------- behavioural data_path ----------------
  logic [15:0] rom [0:7];
  logic [15:0] x_in = 16'h0100;
  logic [7:0]  y_in = 8'h00;
  logic [15:0] dp_x = 16'h0, dp_tmp = 16'h0, dp_ans = 16'h0;
  logic [7:0]  dp_y = 8'h0;
  int   force_abs = 1 << 30;
  logic force_less = 1'b0;

  function automatic logic [15:0] mul_q88(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = a * b;
    return p[23:8];
  endfunction

  always @(posedge clk) begin
    if (ld_x && s4_in) dp_x <= x_in;
    if (ld_y) dp_y <= y_in;
    if (init_tmp) dp_tmp <= 16'h0100;
    else if (ld_tmp) dp_tmp <= mul_q88(s1_x ? dp_x : rom[s3[2:0]], dp_tmp);
    if (init_ans) dp_ans <= 16'h0100;
    else if (ld_ans) dp_ans <= sub ? dp_ans - dp_tmp : dp_ans + dp_tmp;
  end

  always @(negedge clk) force_less <= (cyc >= force_abs);
  assign less_cmp = (dp_tmp < {8'b0, dp_y}) || force_less;

  // ---------------- reference model ----------------
  // Evaluates the series term by term; force_rel is the first cycle (relative
  // to the start edge) from which less_cmp is held high regardless of tmp.
  function automatic void ref_run(input logic [15:0] x, input logic [7:0] y,
                                  input logic a, input int n, input int force_rel,
                                  output int done_rel, output int lds,
                                  output logic [7:0] mask, output logic [15:0] ans);
    logic [15:0] t;
    t = 16'h0100; ans = 16'h0100; mask = 8'h0; lds = 0; done_rel = 0;
    for (int k = 0; k < n; k++) begin
      t = mul_q88(x, t);
      t = mul_q88(rom[k], t);
      if (a && (k % 2 == 0)) begin
        ans = ans - t;
        mask[k] = 1'b1;
      end else begin
        ans = ans + t;
      end
      lds = k + 1;
      done_rel = 6 + 4 * k;
      if ((t < {8'b0, y}) || ((5 + 4 * k) >= force_rel)) break;
    end
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_done_q[$];
  logic [31:0] exp_rel_q[$];
  logic [3:0]  exp_lds_q[$];
  logic [7:0]  exp_mask_q[$];
  logic [15:0] exp_ans_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_expect(input int start_c, input logic [15:0] x, input logic [7:0] y,
                             input logic a, input int force_rel);
    int d, l;
    logic [7:0] m;
    logic [15:0] an;
    ref_run(x, y, a, 8, force_rel, d, l, m, an);
    exp_done_q.push_back(32'(start_c + d));
    exp_rel_q.push_back(32'(d));
    exp_lds_q.push_back(4'(l));
    exp_mask_q.push_back(m);
    exp_ans_q.push_back(an);
  endtask

  // ---------------- monitor ----------------
  int mon_busy = 0;
  int mon_lds = 0;
  logic [7:0] mon_mask = 8'h0;

  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 0; mon_lds = 0; mon_mask = 8'h0;
    end else begin
      if (busy) begin
        mon_busy++;
        if (mon_busy == 1)
          chk("load_ctrl", {27'b0, ld_x, s4_in, ld_y, init_tmp, init_ans}, 32'h1f);
        if (ld_ans) begin
          chk("s3_index", {24'b0, s3}, 32'(mon_lds));
          if (sub) mon_mask[mon_lds[2:0]] = 1'b1;
          mon_lds++;
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", 32'(cyc), 32'hffffffff);
        end else begin
          chk("done_cycle", 32'(cyc), exp_done_q.pop_front());
          chk("busy_cycles", 32'(mon_busy), exp_rel_q.pop_front());
          chk("ld_ans_count", 32'(mon_lds), {28'b0, exp_lds_q.pop_front()});
          chk("sub_mask", {24'b0, mon_mask}, {24'b0, exp_mask_q.pop_front()});
          chk("ans_value", {16'b0, dp_ans}, {16'b0, exp_ans_q.pop_front()});
        end
        mon_busy = 0; mon_lds = 0; mon_mask = 8'h0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain();
    int budget = 0;
    while (exp_done_q.size() != 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (exp_done_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d_pending required=0_pending", exp_done_q.size());
      exp_done_q.delete(); exp_rel_q.delete(); exp_lds_q.delete();
      exp_mask_q.delete(); exp_ans_q.delete();
    end
    force_abs = 1 << 30;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_one(input logic [15:0] x, input logic [7:0] y, input logic a,
                         input int force_rel, input logic extra_start);
    int start_c, d, l, r;
    logic [7:0] m;
    logic [15:0] an;
    @(negedge clk);
    start_c = cyc;
    push_expect(start_c, x, y, a, force_rel);
    ref_run(x, y, a, 8, force_rel, d, l, m, an);
    x_in = x; y_in = y; alt = a; start = 1'b1;
    force_abs = (force_rel >= 1000) ? (1 << 30) : (start_c + force_rel);
    @(negedge clk);
    start = 1'b0;
    alt = 1'($urandom);
    if (extra_start) begin
      r = $urandom_range(d - 1, 2);
      repeat (r - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_drain();
  endtask

  task automatic run_b2b(input logic [15:0] x, input logic [7:0] y, input logic a);
    int start_c, start_c2, d, l, budget;
    logic [7:0] m;
    logic [15:0] an;
    @(negedge clk);
    start_c = cyc;
    ref_run(x, y, a, 8, 1 << 30, d, l, m, an);
    start_c2 = start_c + d + 1;
    push_expect(start_c, x, y, a, 1 << 30);
    push_expect(start_c2, x, y, a, 1 << 30);
    x_in = x; y_in = y; alt = a; start = 1'b1;
    budget = 0;
    while (cyc < start_c2 + 1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    start = 1'b0;
    wait_drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [22:0] outs;
    int d4, l4, r4_done, r4_lds;
    logic [7:0] m4, mon4;
    logic [15:0] an4;

    rom[0] = 16'h0100; rom[1] = 16'h0080; rom[2] = 16'h0055; rom[3] = 16'h0040;
    rom[4] = 16'h0033; rom[5] = 16'h002B; rom[6] = 16'h0025; rom[7] = 16'h0020;

    repeat (2) @(negedge clk);
    outs = {busy, done, ld_x, ld_y, s4_in, s4_mult, init_tmp, init_ans, ld_tmp,
            ld_ans, sub, s1_rom, s1_x, s2_tmp, s2_x, s3};
    chk("reset_outputs", {9'b0, outs}, 32'h0);
    chk("reset_state", {25'b0, dbg_state}, {25'b0, S_IDLE});
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full run: never below threshold, done in cycle 34.
    run_one(16'h0100, 8'h00, 1'b0, 1 << 30, 1'b0);
    // Early exit: less_cmp held from cycle 10, done in cycle 14.
    run_one(16'h0100, 8'h00, 1'b0, 10, 1'b0);
    // Integration: x = 1.0, y = 1 LSB, stops at the first term below it.
    run_one(16'h0100, 8'h01, 1'b0, 1 << 30, 1'b0);
    // Ignored start while busy.
    run_one(16'h0100, 8'h00, 1'b1, 1 << 30, 1'b1);
    // Back-to-back with start held high.
    run_b2b(16'h00C0, 8'h02, 1'b1);

    // Mid-run reset in cycle 9.
    @(negedge clk);
    x_in = 16'h0100; y_in = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    outs = {busy, done, ld_x, ld_y, s4_in, s4_mult, init_tmp, init_ans, ld_tmp,
            ld_ans, sub, s1_rom, s1_x, s2_tmp, s2_x, s3};
    chk("midrun_reset_outputs", {9'b0, outs}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      outs = {busy, done, ld_x, ld_y, s4_in, s4_mult, init_tmp, init_ans, ld_tmp,
              ld_ans, sub, s1_rom, s1_x, s2_tmp, s2_x, s3};
      chk("held_reset_outputs", {9'b0, outs}, 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    run_one(16'h0100, 8'h04, 1'b0, 1 << 30, 1'b0);

    // Randomized runs.
    for (int n = 0; n < 12; n++) begin
      run_one(16'($urandom_range(16'h0180, 16'h0040)), 8'($urandom_range(48, 0)),
              1'($urandom), ($urandom_range(3, 0) == 0) ? int'($urandom_range(30, 6)) : (1 << 30),
              1'($urandom));
    end

    // Alternating sign on the N_TERMS = 4 instance.
    ref_run(16'h0100, 8'h00, 1'b1, 4, 1 << 30, d4, l4, m4, an4);
    @(negedge clk);
    alt4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; alt4 = 1'b0;
    r4_done = 0; r4_lds = 0; mon4 = 8'h0;
    for (int r = 1; r <= 60; r++) begin
      if (ld_ans4) begin
        if (sub4) mon4[s3_4[2:0]] = 1'b1;
        r4_lds++;
      end
      if (done4) begin
        r4_done = r;
        break;
      end
      @(negedge clk);
    end
    chk("n4_done_cycle", 32'(r4_done), 32'(d4));
    chk("n4_sub_mask", {24'b0, mon4}, {24'b0, m4});
    chk("n4_ld_ans_count", 32'(r4_lds), 32'(l4));
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
